// File: rtl/indicator_pkg.sv
// Shared types and constants for the front-panel indicator driver; the blink-count
// defaults are also used by the booking controller.
package indicator_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ON   = 2'd1,
        ST_OFF  = 2'd2
    } state_e;

    localparam logic PAT_OK  = 1'b0;
    localparam logic PAT_ERR = 1'b1;

    localparam logic [3:0] DEF_OK_BLINKS  = 4'd1;
    localparam logic [3:0] DEF_ERR_BLINKS = 4'd3;

endpackage

// File: rtl/indicator_driver_if.sv
// Event/indicator bundle between the booking controller and the indicator driver.
// Event pulses are single-cycle strobes with no back-pressure; every output is registered.
interface indicator_driver_if;
    import indicator_pkg::*;

    logic   ok_pulse;
    logic   err_pulse;
    logic   led_out;
    logic   busy;
    logic   is_err;
    logic   done_pulse;
    state_e state;

    modport slave (
        input  ok_pulse, err_pulse,
        output led_out, busy, is_err, done_pulse, state
    );

    modport master (
        output ok_pulse, err_pulse,
        input  led_out, busy, is_err, done_pulse, state
    );

endinterface

// File: rtl/indicator_driver_phase_timer.sv
// Loadable down-counter timing each ON/OFF phase; holds at zero instead of wrapping.
module phase_timer #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             zero
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= load_val;
        end else if (r_count != '0) begin
            r_count <= r_count - {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign zero = (r_count == '0);

endmodule

// File: rtl/indicator_driver.sv
// Turns one-cycle ok/err events into long blink patterns on the indicator pin,
// with error events preempting an ok pattern in progress.
module indicator_driver
    import indicator_pkg::*;
#(
    parameter int               CNT_W      = 16,
    parameter logic [CNT_W-1:0] ON_CYCLES  = 16'hFFFF,
    parameter logic [CNT_W-1:0] OFF_CYCLES = 16'hFFFF,
    parameter logic [3:0]       OK_BLINKS  = DEF_OK_BLINKS,
    parameter logic [3:0]       ERR_BLINKS = DEF_ERR_BLINKS
) (
    input  logic               clk,
    input  logic               rst,
    indicator_driver_if.slave  bus
);

    localparam logic [CNT_W-1:0] ONE      = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] ON_LOAD  = ON_CYCLES - ONE;
    localparam logic [CNT_W-1:0] OFF_LOAD = OFF_CYCLES - ONE;

    state_e     r_state;
    logic [3:0] r_blinks;
    logic       r_is_err;
    logic       r_led;
    logic       r_busy;
    logic       r_done;

    state_e           w_state_nxt;
    logic [3:0]       w_blinks_nxt;
    logic             w_is_err_nxt;
    logic             w_done;
    logic             w_load;
    logic [CNT_W-1:0] w_load_val;
    logic             w_zero;
    logic             w_start_err;
    logic             w_start_ok;

    phase_timer #(.CNT_W(CNT_W)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (w_load),
        .load_val (w_load_val),
        .zero     (w_zero)
    );

    // An error restarts anything except another error; ok only starts from idle.
    assign w_start_err = bus.err_pulse && ((r_state == ST_IDLE) || (r_is_err == PAT_OK));
    assign w_start_ok  = bus.ok_pulse && !bus.err_pulse && (r_state == ST_IDLE);

    always_comb begin
        w_state_nxt  = r_state;
        w_blinks_nxt = r_blinks;
        w_is_err_nxt = r_is_err;
        w_done       = 1'b0;
        w_load       = 1'b0;
        w_load_val   = '0;
        if (w_start_err) begin
            w_state_nxt  = ST_ON;
            w_blinks_nxt = ERR_BLINKS;
            w_is_err_nxt = PAT_ERR;
            w_load       = 1'b1;
            w_load_val   = ON_LOAD;
        end else if (w_start_ok) begin
            w_state_nxt  = ST_ON;
            w_blinks_nxt = OK_BLINKS;
            w_is_err_nxt = PAT_OK;
            w_load       = 1'b1;
            w_load_val   = ON_LOAD;
        end else begin
            case (r_state)
                ST_ON: begin
                    if (w_zero) begin
                        w_state_nxt = ST_OFF;
                        w_load      = 1'b1;
                        w_load_val  = OFF_LOAD;
                        if (r_blinks != 4'd0) begin
                            w_blinks_nxt = r_blinks - 4'd1;
                        end
                    end
                end
                ST_OFF: begin
                    if (w_zero) begin
                        if (r_blinks != 4'd0) begin
                            w_state_nxt = ST_ON;
                            w_load      = 1'b1;
                            w_load_val  = ON_LOAD;
                        end else begin
                            w_state_nxt = ST_IDLE;
                            w_done      = 1'b1;
                        end
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // Outputs are registered from the next state so they line up with r_state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_blinks <= 4'd0;
            r_is_err <= 1'b0;
            r_led    <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_blinks <= w_blinks_nxt;
            r_is_err <= w_is_err_nxt;
            r_led    <= (w_state_nxt == ST_ON);
            r_busy   <= (w_state_nxt != ST_IDLE);
            r_done   <= w_done;
        end
    end

    assign bus.led_out    = r_led;
    assign bus.busy       = r_busy;
    assign bus.is_err     = r_is_err;
    assign bus.done_pulse = r_done;
    assign bus.state      = r_state;

endmodule

// File: tb/tb_indicator_driver.sv
// Directed bench for indicator_driver with ON=4, OFF=3, OK=1, ERR=3; outputs are
// compared as {led_out, busy, is_err, done_pulse} one cycle at a time.
module tb_indicator_driver;
    import indicator_pkg::*;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;

    indicator_driver_if bus ();

    indicator_driver #(
        .CNT_W      (16),
        .ON_CYCLES  (16'd4),
        .OFF_CYCLES (16'd3),
        .OK_BLINKS  (4'd1),
        .ERR_BLINKS (4'd3)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [3:0] exp);
        logic [3:0] obs;
        obs = {bus.led_out, bus.busy, bus.is_err, bus.done_pulse};
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got {led,busy,err,done}=%b expected %b", tag, obs, exp);
        end
    endtask

    // Present an event for one edge; returns in the first cycle after it was sampled.
    task automatic pulse(input logic ok, input logic err);
        bus.ok_pulse  = ok;
        bus.err_pulse = err;
        step();
        bus.ok_pulse  = 1'b0;
        bus.err_pulse = 1'b0;
    endtask

    // Checks n blinks of 4 on / 3 off starting at the current cycle, ending on the
    // done cycle (not stepped past). Optionally injects an event at pattern cycle inj_cyc.
    task automatic check_pattern(input string tag, input int n, input logic err,
                                 input int inj_cyc, input logic inj_ok, input logic inj_err);
        int c;
        c = 1;
        for (int b = 0; b < n; b++) begin
            for (int i = 0; i < 7; i++) begin
                chk(tag, (i < 4) ? {1'b1, 1'b1, err, 1'b0} : {1'b0, 1'b1, err, 1'b0});
                if (c == inj_cyc) begin
                    pulse(inj_ok, inj_err);
                end else begin
                    step();
                end
                c++;
            end
        end
        chk({tag, "_done"}, {1'b0, 1'b0, err, 1'b1});
    endtask

    initial begin
        n_vec         = 0;
        n_err         = 0;
        rst           = 1'b1;
        bus.ok_pulse  = 1'b0;
        bus.err_pulse = 1'b0;

        step();
        step();
        chk("reset", 4'b0000);
        n_vec++;
        assert (bus.state === ST_IDLE) else begin
            n_err++;
            $error("FAIL reset_state: got %0d expected %0d", bus.state, ST_IDLE);
        end
        pulse(1'b1, 1'b0);
        chk("ok_in_reset", 4'b0000);
        rst = 1'b0;
        step();
        chk("ok_in_reset_after", 4'b0000);

        pulse(1'b1, 1'b0);
        check_pattern("ok", 1, 1'b0, -1, 1'b0, 1'b0);
        step();
        chk("ok_idle", 4'b0000);

        pulse(1'b0, 1'b1);
        check_pattern("err", 3, 1'b1, -1, 1'b0, 1'b0);
        step();
        chk("err_idle", 4'b0010);

        pulse(1'b1, 1'b0);
        chk("ok_clears_is_err", 4'b1100);
        check_pattern("ok_short", 1, 1'b0, -1, 1'b0, 1'b0);
        step();

        pulse(1'b1, 1'b1);
        check_pattern("both", 3, 1'b1, -1, 1'b0, 1'b0);
        step();
        chk("both_idle", 4'b0010);

        pulse(1'b1, 1'b0);
        chk("pre_c1", 4'b1100);
        step();
        chk("pre_c2", 4'b1100);
        pulse(1'b0, 1'b1);
        check_pattern("preempt", 3, 1'b1, -1, 1'b0, 1'b0);
        step();
        chk("preempt_idle", 4'b0010);

        pulse(1'b0, 1'b1);
        check_pattern("ok_in_err", 3, 1'b1, 5, 1'b1, 1'b0);
        step();

        pulse(1'b0, 1'b1);
        check_pattern("err_in_err", 3, 1'b1, 9, 1'b0, 1'b1);
        step();

        pulse(1'b1, 1'b0);
        check_pattern("b2b_first", 1, 1'b0, -1, 1'b0, 1'b0);
        pulse(1'b1, 1'b0);
        check_pattern("b2b_second", 1, 1'b0, -1, 1'b0, 1'b0);
        step();
        chk("b2b_idle", 4'b0000);

        pulse(1'b0, 1'b1);
        for (int c = 1; c <= 9; c++) begin
            chk("rst_mid", (((c - 1) % 7) < 4) ? 4'b1110 : 4'b0110);
            step();
        end
        chk("rst_mid_c10", 4'b1110);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_mid_after", 4'b0000);
        step();
        chk("rst_mid_after2", 4'b0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
